// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops bytes from a registered-output FIFO and sends each as an 8N1/8N2 UART frame.
module uart_tx_drain #(
    parameter int CLOCKS_PER_BIT = 868,
    parameter int DATA_WIDTH     = 8,
    parameter int STOP_BITS      = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_full,
    input  logic                  fifo_push,
    output logic                  fifo_write_enable,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH + STOP_BITS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_POP   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [CW-1:0]         r_baud;
    logic [BW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift;
    logic                  r_tx;
    logic                  w_tx;
    logic                  w_baud_done;
    logic                  w_bit_last;
    logic                  w_accept;
    logic                  w_timing;

    always_comb begin
        w_baud_done = r_baud == BAUD_LAST;
        w_bit_last  = r_bit == (r_state == S_STOP ? STOP_LAST : DATA_LAST);
        // a push into a full FIFO makes it ignore our pop in the same cycle
        w_accept    = !fifo_empty && !(fifo_push && fifo_full);
        w_timing    = r_state == S_START || r_state == S_DATA || r_state == S_STOP;
        w_next      = r_state;
        case (r_state)
            S_IDLE:  if (enable && !fifo_empty) w_next = S_POP;
            S_POP:   w_next = w_accept ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = S_START;
            S_START: if (w_baud_done) w_next = S_DATA;
            S_DATA:  if (w_baud_done && w_bit_last) w_next = S_STOP;
            S_STOP:  if (w_baud_done && w_bit_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        w_shift = r_state == S_LOAD ? fifo_data_out :
                  (r_state == S_DATA && w_baud_done) ? r_shift >> 1 : r_shift;
        // tx is registered, so it is computed from where the FSM is heading
        w_tx    = w_next == S_START ? 1'b0 : w_next == S_DATA ? w_shift[0] : 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_next;
            r_shift <= w_shift;
            r_tx    <= w_tx;
            r_baud  <= (w_next != r_state || w_baud_done || !w_timing) ? '0 : r_baud + 1'b1;
            r_bit   <= (w_next != r_state) ? '0 : (w_baud_done && w_timing) ? r_bit + 1'b1 : r_bit;
        end
    end

    assign fifo_write_enable = r_state == S_POP;
    assign busy              = r_state != S_IDLE;
    assign frame_done        = r_state == S_STOP && w_baud_done && w_bit_last;
    assign tx                = r_tx;
endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: randomized checks of uart_tx_drain against a FIFO model and a per-cycle frame waveform model.
module tb_uart_tx_drain;
    localparam int CPB   = 4;
    localparam int DW    = 8;
    localparam int SB    = 1;
    localparam int FRAME = (1 + DW + SB) * CPB;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_full = 1'b0;
    logic       fifo_push = 1'b0;
    logic [7:0] fifo_data_out;
    logic       fifo_empty;
    logic       fifo_write_enable;
    logic       tx;
    logic       busy;
    logic       frame_done;

    logic [7:0] mem [0:63];
    int         head = 0;
    int         tail = 0;
    int         npop = 0;
    int         cyc = 0;
    int         we_cyc = 0;
    int         we_double = 0;
    logic       prev_we = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clock = ~clock;

    uart_tx_drain #(.CLOCKS_PER_BIT(CPB), .DATA_WIDTH(DW), .STOP_BITS(SB)) dut (
        .clock(clock),
        .resetn(resetn),
        .enable(enable),
        .fifo_data_out(fifo_data_out),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full),
        .fifo_push(fifo_push),
        .fifo_write_enable(fifo_write_enable),
        .tx(tx),
        .busy(busy),
        .frame_done(frame_done)
    );

    assign fifo_empty = (head == tail);

    // FIFO read side: registered output, zero unless a pop was accepted last cycle
    always @(posedge clock or negedge resetn) begin
        if (!resetn) fifo_data_out <= '0;
        else if (fifo_write_enable && head != tail && !(fifo_push && fifo_full)) begin
            fifo_data_out <= mem[head % 64];
            head          <= head + 1;
            npop          <= npop + 1;
        end else fifo_data_out <= '0;
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (fifo_write_enable) begin
            if (prev_we) we_double <= we_double + 1;
            we_cyc <= cyc;
        end
        prev_we <= fifo_write_enable;
    end

    task automatic push(input logic [7:0] b);
        mem[tail % 64] = b;
        tail = tail + 1;
    endtask

    task automatic wait_low(output int gap);
        gap = 0;
        @(negedge clock);
        while (tx !== 1'b0 && gap < 300) begin
            gap++;
            @(negedge clock);
        end
    endtask

    task automatic frame(input logic [7:0] b, input int exp_gap, input int drop_at);
        int gap;
        int errs;
        logic [DW+SB:0] fr;
        logic exp_bit;
        fr = {{SB{1'b1}}, b, 1'b0};
        wait_low(gap);
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_start byte %02h: tx=%b after %0d cycles, required 0", b, tx, gap);
        end else begin
            if (exp_gap >= 0) begin
                vectors++;
                if (gap !== exp_gap) begin
                    miscompares++;
                    $display("FAIL idle_gap byte %02h: got %0d idle cycles, required %0d", b, gap, exp_gap);
                end
            end
            vectors++;
            if (cyc !== we_cyc + 2) begin
                miscompares++;
                $display("FAIL pop_latency byte %02h: start at pop+%0d, required pop+2", b, cyc - we_cyc);
            end
            errs = 0;
            for (int c = 0; c < FRAME; c++) begin
                if (c > 0) @(negedge clock);
                if (c == drop_at) enable = 1'b0;
                exp_bit = fr[c / CPB];
                if (tx !== exp_bit || frame_done !== (c == FRAME - 1) || busy !== 1'b1) begin
                    if (errs == 0)
                        $display("FAIL frame_bits byte %02h cycle %0d: tx=%b done=%b busy=%b, required tx=%b done=%b busy=1",
                                 b, c, tx, frame_done, busy, exp_bit, c == FRAME - 1);
                    errs++;
                end
            end
            vectors++;
            if (errs != 0) miscompares++;
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        vectors++;
        if ({tx, busy, fifo_write_enable, frame_done} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_state: tx/busy/we/done=%b, required 1000", {tx, busy, fifo_write_enable, frame_done});
        end
        #2 resetn = 1'b1;
    endtask

    task automatic test_idle_empty();
        int errs = 0;
        enable = 1'b1;
        repeat (100) begin
            @(negedge clock);
            if (fifo_write_enable !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        vectors++;
        if (errs != 0) begin
            miscompares++;
            $display("FAIL idle_empty: %0d bad cycles, required 0", errs);
        end
        enable = 1'b0;
    endtask

    task automatic test_single();
        int n0 = npop;
        push(8'hA5);
        enable = 1'b1;
        frame(8'hA5, -1, -1);
        repeat (4) @(negedge clock);
        vectors++;
        if (npop - n0 !== 1) begin
            miscompares++;
            $display("FAIL single_pops: %0d pops, required 1", npop - n0);
        end
        vectors++;
        if (fifo_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL single_empty: fifo_empty=%b, required 1", fifo_empty);
        end
        enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        push(8'h00);
        push(8'hFF);
        enable = 1'b1;
        frame(8'h00, -1, -1);
        frame(8'hFF, 3, -1);
        enable = 1'b0;
    endtask

    task automatic test_reject();
        logic [7:0] h = 8'($urandom);
        int n = 0;
        int errs = 0;
        push(h);
        fifo_full = 1'b1;
        fifo_push = 1'b1;
        enable    = 1'b1;
        @(negedge clock);
        while (!fifo_write_enable && n < 20) begin
            n++;
            @(negedge clock);
        end
        vectors++;
        if (fifo_write_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL reject_attempt: we=%b, required 1", fifo_write_enable);
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (fifo_write_enable !== (c % 2 == 0) || tx !== 1'b1 || fifo_empty !== 1'b0) errs++;
        end
        vectors++;
        if (errs != 0) begin
            miscompares++;
            $display("FAIL reject_retry: %0d bad cycles, required 0", errs);
        end
        fifo_full = 1'b0;
        fifo_push = 1'b0;
        frame(h, -1, -1);
        enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b1 = 8'($urandom) & 8'hF7;
        logic [7:0] b2 = 8'($urandom);
        int gap;
        push(b1);
        push(b2);
        enable = 1'b1;
        wait_low(gap);
        repeat ((1 + 3) * CPB + 1) @(negedge clock);
        #2;
        vectors++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_bit3: tx=%b busy=%b, required tx=0 busy=1", tx, busy);
        end
        resetn = 1'b0;
        #1;
        vectors++;
        if ({tx, busy, fifo_write_enable, frame_done} !== 4'b1000) begin
            miscompares++;
            $display("FAIL async_reset: tx/busy/we/done=%b, required 1000", {tx, busy, fifo_write_enable, frame_done});
        end
        @(negedge clock);
        #2 resetn = 1'b1;
        frame(b2, -1, -1);
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        logic [7:0] b2 = 8'($urandom);
        int errs = 0;
        push(8'h3C);
        push(b2);
        enable = 1'b1;
        frame(8'h3C, -1, 10);
        repeat (50) begin
            @(negedge clock);
            if (fifo_write_enable !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        vectors++;
        if (errs != 0) begin
            miscompares++;
            $display("FAIL enable_low_idle: %0d bad cycles, required 0", errs);
        end
        vectors++;
        if (fifo_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_low_kept: fifo_empty=%b, required 0", fifo_empty);
        end
        enable = 1'b1;
        frame(b2, -1, -1);
        enable = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] q [6];
        foreach (q[i]) begin
            q[i] = 8'($urandom);
            push(q[i]);
        end
        enable = 1'b1;
        foreach (q[i]) frame(q[i], i == 0 ? -1 : 3, -1);
        enable = 1'b0;
    endtask

    task automatic test_we_pulse();
        vectors++;
        if (we_double !== 0) begin
            miscompares++;
            $display("FAIL we_pulse: %0d double-cycle pops, required 0", we_double);
        end
    endtask

    initial begin
        test_reset();
        test_idle_empty();
        test_single();
        test_back_to_back();
        test_reject();
        test_reset_mid();
        test_enable_drop();
        test_random();
        test_we_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Consumer end of the buffered-UART FIFO: pops bytes from the FIFO's output side and serializes each as an asynchronous 8N1 (or 8N2) UART frame on `tx`. It sits between the FIFO (driving its `write_enable` pop request and reading its registered `data_out`) and the serial pin. It handles the FIFO's one-cycle read latency and its pop-suppression rule.

## Interface
- `CLOCKS_PER_BIT`, 868, clock cycles per serial bit (100 MHz / 115200); must be ≥ 2.
- `DATA_WIDTH`, 8, bits per character; must equal FIFO width.
- `STOP_BITS`, 1, number of stop bits (1 or 2).

- `clock`  in  1  sole clock; all logic on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, no new pop is started; a frame in flight completes.
- `fifo_data_out`  in  DATA_WIDTH  FIFO registered output; valid the cycle after an accepted pop, 0 otherwise.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_push`  in  1  copy of the producer's push request (FIFO `read_enable`) this cycle.
- `fifo_write_enable`  out  1  pop request to FIFO; high for exactly one cycle per attempt.
- `tx`  out  1  serial line, idle high; registered.
- `busy`  out  1  high whenever state ≠ IDLE.
- `frame_done`  out  1  one-cycle pulse in the last cycle of the final stop bit.

## Operation
- States: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE: `tx`=1. If `enable && !fifo_empty` → POP.
- POP: `fifo_write_enable`=1 (decoded from state). Pop accepted iff `!fifo_empty && !(fifo_push && fifo_full)`; the FIFO ignores both requests when a push meets a full FIFO. Accepted → LOAD; rejected → IDLE (retry later, no data consumed).
- LOAD: capture `fifo_data_out` into shift register; → START.
- START: `tx`=0 for CLOCKS_PER_BIT cycles; → DATA.
- DATA: DATA_WIDTH bits, LSB first, each CLOCKS_PER_BIT cycles; bit index counter 0..DATA_WIDTH-1; → STOP after last bit.
- STOP: `tx`=1 for STOP_BITS×CLOCKS_PER_BIT cycles; `frame_done` pulses in final cycle; → IDLE.
- Baud counter width $clog2(CLOCKS_PER_BIT), counts 0..CLOCKS_PER_BIT-1, cleared on every state entry; no wrap past terminal count.
- `enable` is sampled only in IDLE; deasserting mid-frame does not truncate the frame.
- A captured byte of 0x00 is a legal character; validity comes from the POP acceptance decision, not from data value.

## Timing
- Reset (async, immediate): state IDLE, `tx`=1, `busy`=0, `fifo_write_enable`=0, `frame_done`=0, counters and shift register 0. Reset mid-frame aborts the frame; `tx` goes high without waiting for a clock; the popped byte is lost.
- Pop at cycle P (POP state); byte valid on `fifo_data_out` at P+1 (LOAD); `tx` falls at P+2 edge (START).
- Frame duration from first start-bit cycle: (1+DATA_WIDTH+STOP_BITS)×CLOCKS_PER_BIT cycles.
- Back-to-back frames: last stop cycle → IDLE → POP → LOAD → START, i.e. 3 extra idle-high cycles between frames.
- Rejected pop costs 2 cycles (POP, IDLE) before the next attempt.
- `fifo_write_enable` is never high outside POP, and never high for two consecutive cycles.

## Test plan
- CLOCKS_PER_BIT=4, FIFO holds 0xA5 → one `fifo_write_enable` pulse; `tx` = 0 (4 cyc), then 1,0,1,0,0,1,0,1 (4 cyc each), then 1 (4 cyc); `frame_done` at cycle 40 after start-bit begin; FIFO empty after.
- FIFO empty, `enable`=1 for 100 cycles → `fifo_write_enable` never asserted, `tx`=1, `busy`=0.
- FIFO holds 0x00, 0xFF → two frames, 0x00 sent (not dropped), exactly 3 idle-high cycles between stop of first and start of second.
- FIFO full and `fifo_push`=1 during POP → pop rejected, no frame, return to IDLE; next attempt with `fifo_push`=0 sends the head byte unchanged.
- Assert `resetn`=0 mid DATA bit 3 between clock edges → `tx`=1 and `busy`=0 immediately; after release, next frame starts cleanly with the next FIFO byte.
- `enable` dropped during frame of 0x3C → frame completes intact, no further pops while low; raising `enable` resumes with the next byte.
